// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the five-stage pipeline controller: forwarding select
// encoding, per-stage bookkeeping record and the dependency rule.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 we;
    logic                 is_load;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

  // True when stage s will write the register that a used, nonzero source reads.
  function automatic logic writes_src(stage_info_t s, logic [REG_IDX_W-1:0] src,
                                      logic use_src);
    return use_src && (src != '0) && s.valid && s.we && (s.rd == src);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the core datapath/decoder (master) and the pipeline
// controller (slave): ID-stage decode info in, enables/flushes/selects out.
interface pipe_ctrl_if #(
  parameter int unsigned RW = 5
);
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] id_rd;
  logic          id_rd_we;
  logic          id_is_load;
  logic          ex_redirect;
  logic          mem_ready;

  logic          pc_load;
  logic          if_id_en;
  logic          id_ex_en;
  logic          ex_mem_en;
  logic          mem_wb_en;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic          ex_valid;
  logic          mem_valid;
  logic          wb_valid;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
           id_is_load, ex_redirect, mem_ready,
    input  pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_flush, fwd_a_sel, fwd_b_sel, ex_valid, mem_valid, wb_valid
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
           id_is_load, ex_redirect, mem_ready,
    output pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_flush, fwd_a_sel, fwd_b_sel, ex_valid, mem_valid, wb_valid
  );
endinterface

// File: rtl/pipe_ctrl_fwd_select.sv
// Operand source selection for one source register against a near and a far
// producer stage. A load in the near stage is never a forwarding source.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src_i,
  input  logic                 use_i,
  input  stage_info_t          near_i,
  input  stage_info_t          far_i,
  output fwd_sel_e             sel_o,
  output logic                 near_dep_o
);

  logic far_dep;

  assign near_dep_o = writes_src(near_i, src_i, use_i);
  assign far_dep    = writes_src(far_i, src_i, use_i);

  // Nearest non-load producer wins; far stage is the fallback.
  always_comb begin
    sel_o = FWD_RF;
    if (near_dep_o && !near_i.is_load) begin
      sel_o = FWD_EXMEM;
    end else if (far_dep) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: tracks EX/MEM/WB destination info, detects
// load-use (or, without forwarding, any RAW) hazards, squashes on redirect and
// freezes the whole pipe on data-memory backpressure.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter bit          FWD_EN       = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  pipe_ctrl_if.slave pif
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned CW = $clog2(LOAD_LATENCY + 1);

  stage_info_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [REG_IDX_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic                 ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [RW-1:0]        id_rs1_n, id_rs2_n, id_rd_n;
  logic [REG_IDX_W-1:0] id_rs1_x, id_rs2_x, id_rd_x;
  logic                 id_use1, id_use2;

  fwd_sel_e             id_a_sel, id_b_sel, ex_a_sel, ex_b_sel;
  logic                 id_a_near, id_b_near;
  logic                 ex_a_near_unused, ex_b_near_unused;
  logic                 ld_use, wb_dep_id, raw_any, data_stall;

  logic                 pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic                 if_id_flush, id_ex_flush;

  assign id_rs1_n = pif.id_rs1[RW-1:0];
  assign id_rs2_n = pif.id_rs2[RW-1:0];
  assign id_rd_n  = pif.id_rd[RW-1:0];
  assign id_rs1_x = REG_IDX_W'(id_rs1_n);
  assign id_rs2_x = REG_IDX_W'(id_rs2_n);
  assign id_rd_x  = REG_IDX_W'(id_rd_n);
  assign id_use1  = pif.id_valid & pif.id_use_rs1;
  assign id_use2  = pif.id_valid & pif.id_use_rs2;

  // ID operands against EX (near) and MEM (far): hazard detection.
  fwd_select u_id_a (
    .src_i(id_rs1_x), .use_i(id_use1), .near_i(ex_q), .far_i(mem_q),
    .sel_o(id_a_sel), .near_dep_o(id_a_near)
  );
  fwd_select u_id_b (
    .src_i(id_rs2_x), .use_i(id_use2), .near_i(ex_q), .far_i(mem_q),
    .sel_o(id_b_sel), .near_dep_o(id_b_near)
  );

  // EX operands against MEM (near) and WB (far): forwarding muxes.
  fwd_select u_ex_a (
    .src_i(ex_rs1_q), .use_i(ex_use1_q), .near_i(mem_q), .far_i(wb_q),
    .sel_o(ex_a_sel), .near_dep_o(ex_a_near_unused)
  );
  fwd_select u_ex_b (
    .src_i(ex_rs2_q), .use_i(ex_use2_q), .near_i(mem_q), .far_i(wb_q),
    .sel_o(ex_b_sel), .near_dep_o(ex_b_near_unused)
  );

  // A MEM dependency shows up as a non-RF select on the ID instances, so the
  // no-forwarding hazard covers EX, MEM and (explicitly) WB.
  assign ld_use    = ex_q.is_load & (id_a_near | id_b_near);
  assign wb_dep_id = writes_src(wb_q, id_rs1_x, id_use1) |
                     writes_src(wb_q, id_rs2_x, id_use2);
  assign raw_any   = id_a_near | id_b_near | wb_dep_id |
                     (id_a_sel != FWD_RF) | (id_b_sel != FWD_RF);

  // Data stall source: load-use counter with forwarding, any RAW without.
  always_comb begin
    if (FWD_EN) begin
      data_stall = ld_use | (cnt_q != '0);
    end else begin
      data_stall = raw_any;
    end
  end

  // Enables and flushes: reset > freeze > redirect > data stall > advance.
  always_comb begin
    pc_load     = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst_n) begin
      pc_load     = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!pif.mem_ready) begin
      pc_load   = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (pif.ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (data_stall) begin
      pc_load     = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Next-state: stage info shifts unless frozen; counter loads/decrements.
  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    ex_rs1_d  = ex_rs1_q;
    ex_rs2_d  = ex_rs2_q;
    ex_use1_d = ex_use1_q;
    ex_use2_d = ex_use2_q;
    cnt_d     = cnt_q;
    if (pif.mem_ready) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (id_ex_flush) begin
        ex_d      = STAGE_BUBBLE;
        ex_rs1_d  = '0;
        ex_rs2_d  = '0;
        ex_use1_d = 1'b0;
        ex_use2_d = 1'b0;
      end else begin
        ex_d      = '{valid: pif.id_valid, rd: id_rd_x, we: pif.id_rd_we,
                      is_load: pif.id_is_load};
        ex_rs1_d  = id_rs1_x;
        ex_rs2_d  = id_rs2_x;
        ex_use1_d = id_use1;
        ex_use2_d = id_use2;
      end
      // The trigger cycle is itself the first bubble, so load LATENCY-1.
      if (pif.ex_redirect) begin
        cnt_d = '0;
      end else if (FWD_EN && ld_use) begin
        cnt_d = CW'(LOAD_LATENCY - 1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= STAGE_BUBBLE;
      mem_q     <= STAGE_BUBBLE;
      wb_q      <= STAGE_BUBBLE;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_use1_q <= ex_use1_d;
      ex_use2_q <= ex_use2_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pif.pc_load     = pc_load;
  assign pif.if_id_en    = if_id_en;
  assign pif.id_ex_en    = id_ex_en;
  assign pif.ex_mem_en   = ex_mem_en;
  assign pif.mem_wb_en   = mem_wb_en;
  assign pif.if_id_flush = if_id_flush;
  assign pif.id_ex_flush = id_ex_flush;
  assign pif.fwd_a_sel   = (FWD_EN && rst_n) ? ex_a_sel : FWD_RF;
  assign pif.fwd_b_sel   = (FWD_EN && rst_n) ? ex_b_sel : FWD_RF;
  assign pif.ex_valid    = ex_q.valid;
  assign pif.mem_valid   = mem_q.valid;
  assign pif.wb_valid    = wb_q.valid;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a forwarding instance (LOAD_LATENCY=3) and a
// non-forwarding instance share redirect/backpressure; each has its own
// instruction stream. A reference pipeline model pushes the expected control
// word every cycle; a monitor pops and compares on the falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.RW(5)) if0 ();
  pipe_ctrl_if #(.RW(5)) if1 ();

  pipe_ctrl #(.NREGS(32), .LOAD_LATENCY(3), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .pif(if0.slave)
  );
  pipe_ctrl #(.NREGS(32), .LOAD_LATENCY(2), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .pif(if1.slave)
  );

  typedef struct packed {
    logic v; logic [4:0] rd; logic we; logic ld;
    logic u1; logic [4:0] rs1; logic u2; logic [4:0] rs2;
  } ins_t;
  localparam ins_t NOP = '0;

  typedef struct { int dut; int cyc; logic [13:0] exp; } sb_t;
  sb_t  sb[$];
  int   errors = 0, checks = 0, cyc = 0;

  ins_t m_id [2], m_ex [2], m_mem [2], m_wb [2];
  int   m_pend [2];
  int   ll [2] = '{3, 2};
  bit   fwd [2] = '{1'b1, 1'b0};
  ins_t prog0[$], prog1[$];
  logic redir = 1'b0, mrdy = 1'b1;

  logic [13:0] act0, act1;
  assign act0 = {if0.pc_load, if0.if_id_en, if0.id_ex_en, if0.ex_mem_en, if0.mem_wb_en,
                 if0.if_id_flush, if0.id_ex_flush, if0.fwd_a_sel, if0.fwd_b_sel,
                 if0.ex_valid, if0.mem_valid, if0.wb_valid};
  assign act1 = {if1.pc_load, if1.if_id_en, if1.id_ex_en, if1.ex_mem_en, if1.mem_wb_en,
                 if1.if_id_flush, if1.id_ex_flush, if1.fwd_a_sel, if1.fwd_b_sel,
                 if1.ex_valid, if1.mem_valid, if1.wb_valid};

  function automatic ins_t mk(bit ld, int rd, int rs1, bit u1, int rs2, bit u2);
    ins_t i = NOP;
    i.v = 1'b1; i.we = 1'b1; i.ld = ld; i.rd = 5'(rd);
    i.rs1 = 5'(rs1); i.u1 = u1; i.rs2 = 5'(rs2); i.u2 = u2;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i.v = ($urandom_range(7) != 0); i.rd = 5'($urandom_range(7));
    i.we = ($urandom_range(5) != 0); i.ld = ($urandom_range(3) == 0);
    i.u1 = ($urandom_range(3) != 0); i.rs1 = 5'($urandom_range(7));
    i.u2 = ($urandom_range(1) != 0); i.rs2 = 5'($urandom_range(7));
    return i;
  endfunction

  function automatic ins_t next_ins(int d);
    if (d == 0 && prog0.size() > 0) return prog0.pop_front();
    if (d == 1 && prog1.size() > 0) return prog1.pop_front();
    return rnd_ins();
  endfunction

  // Producer s writes a register that consumer c reads (x0 never counts).
  function automatic bit wr(ins_t s, logic [4:0] src, logic u);
    return u && src != 5'd0 && s.v && s.we && s.rd == src;
  endfunction
  function automatic bit dep(ins_t s, ins_t c);
    return c.v && (wr(s, c.rs1, c.u1) || wr(s, c.rs2, c.u2));
  endfunction

  function automatic logic [1:0] fsel(int d, logic [4:0] src, logic u);
    if (!fwd[d] || !m_ex[d].v) return 2'b00;
    if (wr(m_mem[d], src, u) && !m_mem[d].ld) return 2'b01;
    if (wr(m_wb[d], src, u)) return 2'b10;
    return 2'b00;
  endfunction

  // Bubbles still owed for the ID instruction (forwarding instance only).
  function automatic int bubbles(int d);
    if (m_pend[d] > 0) return m_pend[d];
    if (m_ex[d].ld && dep(m_ex[d], m_id[d])) return ll[d];
    return 0;
  endfunction

  function automatic bit stall_now(int d);
    if (fwd[d]) return bubbles(d) > 0;
    return dep(m_ex[d], m_id[d]) || dep(m_mem[d], m_id[d]) || dep(m_wb[d], m_id[d]);
  endfunction

  function automatic logic [13:0] expect_word(int d);
    logic [6:0] ctl;
    if (!rst_n)         return 14'b0_0000_11_0000_000;
    if (!mrdy)          ctl = 7'b0_0000_00;
    else if (redir)     ctl = 7'b1_1111_11;
    else if (stall_now(d)) ctl = 7'b0_0111_01;
    else                ctl = 7'b1_1111_00;
    return {ctl, fsel(d, m_ex[d].rs1, m_ex[d].u1), fsel(d, m_ex[d].rs2, m_ex[d].u2),
            m_ex[d].v, m_mem[d].v, m_wb[d].v};
  endfunction

  // One clock of stimulus: drive ID, push expectations, advance model at edge.
  task automatic cycle_run(input bit drop_rst);
    bit st [2];
    int bl [2];
    if0.id_valid = m_id[0].v; if0.id_rd = m_id[0].rd; if0.id_rd_we = m_id[0].we;
    if0.id_is_load = m_id[0].ld; if0.id_rs1 = m_id[0].rs1; if0.id_use_rs1 = m_id[0].u1;
    if0.id_rs2 = m_id[0].rs2; if0.id_use_rs2 = m_id[0].u2;
    if1.id_valid = m_id[1].v; if1.id_rd = m_id[1].rd; if1.id_rd_we = m_id[1].we;
    if1.id_is_load = m_id[1].ld; if1.id_rs1 = m_id[1].rs1; if1.id_use_rs1 = m_id[1].u1;
    if1.id_rs2 = m_id[1].rs2; if1.id_use_rs2 = m_id[1].u2;
    if0.ex_redirect = redir; if1.ex_redirect = redir;
    if0.mem_ready = mrdy;    if1.mem_ready = mrdy;
    if (drop_rst) begin
      #1 rst_n = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      sb.push_back('{dut: d, cyc: cyc, exp: expect_word(d)});
      st[d] = stall_now(d);
      bl[d] = bubbles(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_id[d] = NOP; m_ex[d] = NOP; m_mem[d] = NOP; m_wb[d] = NOP; m_pend[d] = 0;
      end else if (mrdy) begin
        m_wb[d]  = m_mem[d];
        m_mem[d] = m_ex[d];
        if (redir) begin
          m_ex[d] = NOP; m_id[d] = NOP; m_pend[d] = 0;
        end else if (st[d]) begin
          m_ex[d] = NOP;
          m_pend[d] = fwd[d] ? bl[d] - 1 : 0;
        end else begin
          m_ex[d] = m_id[d];
          m_id[d] = next_ins(d);
        end
      end
    end
    cyc++;
    #1;
  endtask

  // Monitor: compare every pushed expectation away from the rising edge.
  initial begin
    sb_t s;
    logic [13:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        s = sb.pop_front();
        a = (s.dut == 0) ? act0 : act1;
        checks++;
        if (a !== s.exp) begin
          errors++;
          $display("FAIL ctl%0d cycle %0d: got %b expected %b", s.dut, s.cyc, a, s.exp);
        end
      end
    end
  end

  initial begin
    ins_t p[$];
    int lu_n = 0, frz_left = 0, n;
    bit red_done = 0, frz_done = 0;
    for (int d = 0; d < 2; d++) begin
      m_id[d] = NOP; m_ex[d] = NOP; m_mem[d] = NOP; m_wb[d] = NOP; m_pend[d] = 0;
    end
    // Directed program: ALU forwarding, x0, three load-use pairs, a RAW pair.
    p.push_back(mk(0, 5, 2, 1, 3, 1));  p.push_back(mk(0, 6, 5, 1, 1, 1));
    p.push_back(mk(0, 5, 2, 1, 3, 0));  p.push_back(mk(0, 9, 10, 1, 11, 1));
    p.push_back(mk(0, 6, 5, 1, 1, 1));
    p.push_back(mk(0, 0, 2, 1, 3, 0));  p.push_back(mk(0, 6, 0, 1, 0, 1));
    for (int k = 0; k < 3; k++) begin
      p.push_back(mk(1, 7, 2, 1, 0, 0)); p.push_back(mk(0, 8, 7, 1, 7, 1));
      p.push_back(mk(0, 9, 10, 1, 11, 1)); p.push_back(mk(0, 12, 10, 1, 11, 0));
    end
    p.push_back(mk(0, 3, 1, 1, 2, 1));  p.push_back(mk(0, 4, 3, 1, 2, 0));
    foreach (p[i]) begin prog0.push_back(p[i]); prog1.push_back(p[i]); end

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle_run(1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      redir = 1'b0; mrdy = 1'b1;
      if (m_pend[0] == 0 && m_ex[0].ld && dep(m_ex[0], m_id[0])) lu_n++;
      if (lu_n == 2 && m_pend[0] == 2 && !red_done) begin redir = 1'b1; red_done = 1; end
      if (lu_n == 3 && m_pend[0] == 1 && !frz_done) begin frz_left = 4; frz_done = 1; end
      if (frz_left > 0) begin mrdy = 1'b0; frz_left--; end
      cycle_run(1'b0);
    end

    for (int i = 0; i < 800; i++) begin
      redir = ($urandom_range(15) == 0);
      mrdy  = ($urandom_range(7) != 0);
      cycle_run(1'b0);
    end

    // Asynchronous reset in the middle of a load-use stall.
    redir = 1'b0; mrdy = 1'b1;
    prog0.push_back(mk(1, 7, 2, 1, 0, 0)); prog0.push_back(mk(0, 8, 7, 1, 7, 1));
    n = 0;
    while (m_pend[0] == 0 && n < 30) begin cycle_run(1'b0); n++; end
    checks++;
    if (m_pend[0] == 0) begin
      errors++;
      $display("FAIL stall_reach: got pending=%0d required >0", m_pend[0]);
    end
    cycle_run(1'b1);
    cycle_run(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle_run(1'b0);

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
